// File: rtl/serial_rca_pkg.sv
// Shared types and constants for the bit-serial ripple-carry subtractor.
// Holds the FSM state enum, the default width and the counter-width helper.
package serial_rca_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder.
// The serial datapath iterates this single cell across the operand bits.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_rca_subtractor.sv
// Bit-serial A-B over one full-adder cell, WIDTH+1-bit sign-extended result.
// Define SERIAL_RCA_ADDSUB_MODE_EN to add a mode port (1 = A+B, 0 = A-B).
module serial_rca_subtractor
  import serial_rca_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_RCA_ADDSUB_MODE_EN
  input  logic             mode,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             carry_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t        state;
  state_t        state_n;
  logic [WIDTH:0] opa;
  logic [WIDTH:0] opb;
  logic [CW-1:0] count;
  logic          carry;
  logic          s;
  logic          cout;
  logic          add;
  logic          accept;
  logic          last;

`ifdef SERIAL_RCA_ADDSUB_MODE_EN
  assign add = mode;
`else
  assign add = 1'b0;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (count == LAST);

  serial_fa_cell u_fa (
    .a   (opa[0]),
    .b   (opb[0]),
    .cin (carry),
    .s   (s),
    .cout(cout)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa       <= '0;
      opb       <= '0;
      count     <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      opa   <= {a[WIDTH-1], a};
      opb   <= add ? {b[WIDTH-1], b} : ~{b[WIDTH-1], b};
      carry <= ~add;
      count <= '0;
    end else if (state == SHIFT) begin
      carry  <= cout;
      result <= {s, result[WIDTH:1]};
      opa    <= opa >> 1;
      opb    <= opb >> 1;
      count  <= count + 1'b1;
      if (last) begin
        carry_out <= cout;
      end
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_rca_subtractor.sv
// Scoreboard bench for serial_rca_subtractor: directed vectors, queued
// expectations, monitor compares on each done pulse.
module tb_serial_rca_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
`ifdef SERIAL_RCA_ADDSUB_MODE_EN
  logic       mode;
`endif
  logic       ready;
  logic       done;
  logic [8:0] result;
  logic       carry_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [8:0] res;
    logic       cy;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];

  serial_rca_subtractor #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef SERIAL_RCA_ADDSUB_MODE_EN
    .mode     (mode),
`endif
    .ready    (ready),
    .done     (done),
    .result   (result),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [8:0] got,
                              input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endfunction

  function automatic void chk_i(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endfunction

  // Monitor: every done cycle must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got done=1 want no pending op");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_carry"}, {8'h0, carry_out}, {8'h0, e.cy});
        chk_i({e.name, "_latency"}, cyc, e.cyc);
        chk({e.name, "_ready_in_done"}, {8'h0, ready}, 9'h0);
      end
    end
  end

  task automatic push_exp(input logic [8:0] er, input logic ec, input string nm);
    exp_t t;
    t.res  = er;
    t.cy   = ec;
    t.cyc  = cyc + 10;
    t.name = nm;
    sb.push_back(t);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready_wait"}, {8'h0, ready}, 9'h1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_i({nm, "_drain_pending"}, sb.size(), 0);
  endtask

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tm, input logic [8:0] er,
                       input logic ec, input string nm);
    @(negedge clk);
    wait_ready(nm);
    a = ta;
    b = tb_;
`ifdef SERIAL_RCA_ADDSUB_MODE_EN
    mode = tm;
`else
    if (tm) $display("note: mode ignored in this build");
`endif
    start = 1'b1;
    push_exp(er, ec, nm);
    @(negedge clk);
    start = 1'b0;
    a = 8'hA5;
    b = 8'h5A;
    chk({nm, "_busy_ready"}, {8'h0, ready}, 9'h0);
    drain(nm);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] r;
    logic       c;
  } vec_t;

  vec_t stream[4];

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
`ifdef SERIAL_RCA_ADDSUB_MODE_EN
    mode  = 1'b0;
`endif
    stream[0] = '{8'd50, 8'd20, 9'h01E, 1'b1};
    stream[1] = '{8'hFF, 8'h01, 9'h1FE, 1'b1};
    stream[2] = '{8'h7F, 8'h80, 9'h0FF, 1'b0};
    stream[3] = '{8'h10, 8'h10, 9'h000, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_ready", {8'h0, ready}, 9'h1);
    chk("reset_done", {8'h0, done}, 9'h0);
    chk("reset_result", result, 9'h000);
    chk("reset_carry", {8'h0, carry_out}, 9'h0);
    rst = 1'b0;

    issue(8'd100, 8'd37, 1'b0, 9'h03F, 1'b1, "sub_100_37");
    issue(8'h00, 8'h01, 1'b0, 9'h1FF, 1'b0, "sub_0_1");
    issue(8'h80, 8'h7F, 1'b0, 9'h101, 1'b1, "sub_m128_127");

    // start held high, operands scrambled while busy
    @(negedge clk);
    wait_ready("stream_start");
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!ready && n < 40) begin
        a = 8'($urandom);
        b = 8'($urandom);
        @(negedge clk);
        n++;
      end
      chk_i($sformatf("stream%0d_ready_wait", i), int'(ready), 1);
      a = stream[i].a;
      b = stream[i].b;
      push_exp(stream[i].r, stream[i].c, $sformatf("stream%0d", i));
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
    end
    start = 1'b0;
    drain("stream");

    // abort in SHIFT after four bits, async reset must clear immediately
    @(negedge clk);
    wait_ready("abort");
    a = 8'd77;
    b = 8'd12;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", {8'h0, ready}, 9'h1);
    chk("abort_done", {8'h0, done}, 9'h0);
    chk("abort_result", result, 9'h000);
    chk("abort_carry", {8'h0, carry_out}, 9'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(8'd5, 8'd3, 1'b0, 9'h002, 1'b1, "post_abort_5_3");

`ifdef SERIAL_RCA_ADDSUB_MODE_EN
    issue(8'h7F, 8'h01, 1'b1, 9'h080, 1'b0, "add_7f_01");
    issue(8'h7F, 8'h01, 1'b0, 9'h07E, 1'b1, "sub_7f_01");
`endif

    repeat (15) @(negedge clk);
    chk_i("final_pending", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
